bp_update_scheduler: RTL and testbench

- Shares the branch predictor's single training/update port between two sources:
  - the commit stage, which is non-speculative and can send up to COMMIT_WIDTH updates per cycle;
  - the branch execute unit (exbru), which is speculative and sends one update per cycle.
- Commit updates are compacted into a FIFO and drained one per cycle.
- Exbru updates take priority but are best-effort, and a starvation guard bounds how long they can stall the FIFO.
- Sits between commit/exbru and branch_predictor.

---
 rtl/bp_update_scheduler_pkg.sv | 23 ++
 rtl/bp_update_scheduler_if.sv | 57 +++++
 rtl/bp_update_scheduler_fifo.sv | 52 +++++
 rtl/bp_update_scheduler.sv | 95 +++++++++
 tb/tb_bp_update_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and sizing for the branch-predictor update scheduler.
package bp_update_scheduler_pkg;

  localparam int unsigned ADDR_WIDTH        = 32;
  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned COMMIT_WIDTH      = 2;
  localparam int unsigned QUEUE_DEPTH       = 8;
  localparam int unsigned STARVE_LIMIT      = 4;

  localparam int unsigned PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned DROP_W   = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         jump;
    logic [ADDR_WIDTH-1:0]        next_pc;
    logic                         hit;
  } bp_update_t;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Commit, exbru and predictor-side signals of the update scheduler.
interface bp_update_scheduler_if;
  import bp_update_scheduler_pkg::*;

  logic [ADDR_WIDTH-1:0]        commit_bp_pc          [0:COMMIT_WIDTH-1];
  logic [INSTRUCTION_WIDTH-1:0] commit_bp_instruction [0:COMMIT_WIDTH-1];
  logic [COMMIT_WIDTH-1:0]      commit_bp_jump;
  logic [ADDR_WIDTH-1:0]        commit_bp_next_pc     [0:COMMIT_WIDTH-1];
  logic [COMMIT_WIDTH-1:0]      commit_bp_hit;
  logic [COMMIT_WIDTH-1:0]      commit_bp_valid;
  logic                         sched_commit_ready;

  logic [ADDR_WIDTH-1:0]        exbru_bp_pc;
  logic [INSTRUCTION_WIDTH-1:0] exbru_bp_instruction;
  logic                         exbru_bp_jump;
  logic [ADDR_WIDTH-1:0]        exbru_bp_next_pc;
  logic                         exbru_bp_hit;
  logic                         exbru_bp_valid;

  logic                         bp_sched_ready;
  logic [ADDR_WIDTH-1:0]        sched_bp_pc;
  logic [INSTRUCTION_WIDTH-1:0] sched_bp_instruction;
  logic                         sched_bp_jump;
  logic [ADDR_WIDTH-1:0]        sched_bp_next_pc;
  logic                         sched_bp_hit;
  logic                         sched_bp_valid;
  logic                         sched_bp_src;

  logic [CNT_W-1:0]             sched_count;
  logic [DROP_W-1:0]            sched_exbru_drop_cnt;
  logic                         sched_overflow;

  modport slave (
    input  commit_bp_pc, commit_bp_instruction, commit_bp_jump, commit_bp_next_pc,
           commit_bp_hit, commit_bp_valid,
    output sched_commit_ready,
    input  exbru_bp_pc, exbru_bp_instruction, exbru_bp_jump, exbru_bp_next_pc,
           exbru_bp_hit, exbru_bp_valid,
    input  bp_sched_ready,
    output sched_bp_pc, sched_bp_instruction, sched_bp_jump, sched_bp_next_pc,
           sched_bp_hit, sched_bp_valid, sched_bp_src,
    output sched_count, sched_exbru_drop_cnt, sched_overflow
  );

  modport master (
    output commit_bp_pc, commit_bp_instruction, commit_bp_jump, commit_bp_next_pc,
           commit_bp_hit, commit_bp_valid,
    input  sched_commit_ready,
    output exbru_bp_pc, exbru_bp_instruction, exbru_bp_jump, exbru_bp_next_pc,
           exbru_bp_hit, exbru_bp_valid,
    output bp_sched_ready,
    input  sched_bp_pc, sched_bp_instruction, sched_bp_jump, sched_bp_next_pc,
           sched_bp_hit, sched_bp_valid, sched_bp_src,
    input  sched_count, sched_exbru_drop_cnt, sched_overflow
  );

endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// Multi-push / single-pop circular buffer; valid lanes are compacted at tail.
module bp_update_scheduler_fifo
  import bp_update_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  bp_update_t              push_data [0:COMMIT_WIDTH-1],
  input  logic [COMMIT_WIDTH-1:0] push_valid,
  input  logic                    pop,
  output bp_update_t              head_data,
  output logic [CNT_W-1:0]        count
);

  bp_update_t       mem [0:QUEUE_DEPTH-1];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] lane_off [0:COMMIT_WIDTH-1];
  logic [COMMIT_WIDTH-1:0] lane_acc;
  logic [CNT_W-1:0] enq_num;

  assign free_slots = CNT_W'(QUEUE_DEPTH) - count;
  assign head_data  = mem[head];

  // Slot offset of each lane = number of accepted lanes below it; lanes past free space are lost.
  always_comb begin
    lane_off = '{default: '0};
    lane_acc = '0;
    enq_num  = '0;
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      lane_off[i] = enq_num;
      lane_acc[i] = push_valid[i] && (enq_num < free_slots);
      if (lane_acc[i]) enq_num = enq_num + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        if (lane_acc[i]) mem[tail + PTR_W'(lane_off[i])] <= push_data[i];
      end
      tail  <= tail + PTR_W'(enq_num);
      head  <= head + PTR_W'(pop);
      count <= count + enq_num - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates the predictor update port between the commit FIFO and speculative exbru
// updates, with a starvation guard and a saturating exbru drop counter.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  bp_update_scheduler_if.slave   bus
);

  bp_update_t            commit_lane [0:COMMIT_WIDTH-1];
  bp_update_t            head;
  logic [CNT_W-1:0]      count;
  logic [STARVE_W-1:0]   starve;
  logic [DROP_W-1:0]     drop_cnt;
  logic                  overflow;
  logic                  fifo_nonempty;
  logic                  commit_ready;
  logic                  exbru_sel;
  logic                  pop;
  logic                  exbru_drop;

  always_comb begin
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      commit_lane[i].pc          = bus.commit_bp_pc[i];
      commit_lane[i].instruction = bus.commit_bp_instruction[i];
      commit_lane[i].jump        = bus.commit_bp_jump[i];
      commit_lane[i].next_pc     = bus.commit_bp_next_pc[i];
      commit_lane[i].hit         = bus.commit_bp_hit[i];
    end
  end

  bp_update_scheduler_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  (commit_lane),
    .push_valid (bus.commit_bp_valid),
    .pop        (pop),
    .head_data  (head),
    .count      (count)
  );

  assign fifo_nonempty = (count != '0);
  assign commit_ready  = (CNT_W'(QUEUE_DEPTH) - count) >= CNT_W'(COMMIT_WIDTH);
  assign exbru_sel     = bus.exbru_bp_valid &&
                         !((starve == STARVE_W'(STARVE_LIMIT)) && fifo_nonempty);
  assign pop           = !rst && !exbru_sel && fifo_nonempty && bus.bp_sched_ready;
  assign exbru_drop    = bus.exbru_bp_valid && (!bus.bp_sched_ready || !exbru_sel);

  // Grant mux; nothing is offered while reset is held.
  always_comb begin
    bus.sched_bp_pc          = head.pc;
    bus.sched_bp_instruction = head.instruction;
    bus.sched_bp_jump        = head.jump;
    bus.sched_bp_next_pc     = head.next_pc;
    bus.sched_bp_hit         = head.hit;
    bus.sched_bp_src         = 1'b0;
    bus.sched_bp_valid       = 1'b0;
    if (!rst) begin
      if (exbru_sel) begin
        bus.sched_bp_pc          = bus.exbru_bp_pc;
        bus.sched_bp_instruction = bus.exbru_bp_instruction;
        bus.sched_bp_jump        = bus.exbru_bp_jump;
        bus.sched_bp_next_pc     = bus.exbru_bp_next_pc;
        bus.sched_bp_hit         = bus.exbru_bp_hit;
        bus.sched_bp_src         = 1'b1;
        bus.sched_bp_valid       = 1'b1;
      end else if (fifo_nonempty) begin
        bus.sched_bp_valid       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop || !fifo_nonempty) begin
        starve <= '0;
      end else if (exbru_sel && bus.bp_sched_ready && (starve != STARVE_W'(STARVE_LIMIT))) begin
        starve <= starve + STARVE_W'(1);
      end
      if (exbru_drop && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + DROP_W'(1);
      if ((bus.commit_bp_valid != '0) && !commit_ready) overflow <= 1'b1;
    end
  end

  assign bus.sched_commit_ready   = commit_ready;
  assign bus.sched_count          = count;
  assign bus.sched_exbru_drop_cnt = drop_cnt;
  assign bus.sched_overflow       = overflow;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with a queue-based reference model checked every cycle.
module tb_bp_update_scheduler;
  import bp_update_scheduler_pkg::*;

  logic clk;
  logic rst;
  bp_update_scheduler_if bif ();

  bp_update_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state
  bp_update_t q [$];
  bp_update_t inc [$];
  int m_starve;
  int m_drops;
  bit m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare outputs against the model, then advance the model by one edge.
  always @(negedge clk) begin
    int sz;
    int free;
    bit sel;
    bit exp_v;
    bit ready_e;
    bp_update_t e;
    sz = q.size();
    if (rst) begin
      chk("rst_valid", 64'(bif.sched_bp_valid), 64'(0));
      q.delete();
      m_starve = 0;
      m_drops  = 0;
      m_ovf    = 1'b0;
    end else begin
      ready_e = (int'(QUEUE_DEPTH) - sz) >= int'(COMMIT_WIDTH);
      sel     = bif.exbru_bp_valid && !(m_starve == int'(STARVE_LIMIT) && sz != 0);
      exp_v   = sel || (sz != 0);
      chk("valid", 64'(bif.sched_bp_valid), 64'(exp_v));
      chk("commit_ready", 64'(bif.sched_commit_ready), 64'(ready_e));
      chk("count", 64'(bif.sched_count), 64'(sz));
      chk("drop_cnt", 64'(bif.sched_exbru_drop_cnt), 64'(m_drops));
      chk("overflow", 64'(bif.sched_overflow), 64'(m_ovf));
      if (exp_v) begin
        if (sel) begin
          e.pc          = bif.exbru_bp_pc;
          e.instruction = bif.exbru_bp_instruction;
          e.jump        = bif.exbru_bp_jump;
          e.next_pc     = bif.exbru_bp_next_pc;
          e.hit         = bif.exbru_bp_hit;
        end else begin
          e = q[0];
        end
        chk("src", 64'(bif.sched_bp_src), 64'(sel));
        chk("pc", 64'(bif.sched_bp_pc), 64'(e.pc));
        chk("instruction", 64'(bif.sched_bp_instruction), 64'(e.instruction));
        chk("jump", 64'(bif.sched_bp_jump), 64'(e.jump));
        chk("next_pc", 64'(bif.sched_bp_next_pc), 64'(e.next_pc));
        chk("hit", 64'(bif.sched_bp_hit), 64'(e.hit));
      end
      free = int'(QUEUE_DEPTH) - sz;
      inc.delete();
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        if (bif.commit_bp_valid[i] && inc.size() < free) begin
          e.pc          = bif.commit_bp_pc[i];
          e.instruction = bif.commit_bp_instruction[i];
          e.jump        = bif.commit_bp_jump[i];
          e.next_pc     = bif.commit_bp_next_pc[i];
          e.hit         = bif.commit_bp_hit[i];
          inc.push_back(e);
        end
      end
      if (bif.commit_bp_valid != '0 && !ready_e) m_ovf = 1'b1;
      if (bif.exbru_bp_valid && (!bif.bp_sched_ready || !sel) && m_drops < 65535) m_drops++;
      if (!sel && sz != 0 && bif.bp_sched_ready) begin
        void'(q.pop_front());
        m_starve = 0;
      end else if (sz == 0) begin
        m_starve = 0;
      end else if (sel && bif.bp_sched_ready && m_starve < int'(STARVE_LIMIT)) begin
        m_starve++;
      end
      foreach (inc[i]) q.push_back(inc[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc);
    bif.commit_bp_pc[i]          = pc;
    bif.commit_bp_instruction[i] = pc ^ 32'h0000_0063;
    bif.commit_bp_jump[i]        = pc[2];
    bif.commit_bp_next_pc[i]     = pc + 32'd8;
    bif.commit_bp_hit[i]         = pc[3];
  endtask

  // Present one commit group for a single cycle.
  task automatic push(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    set_lane(0, pc0);
    set_lane(1, pc1);
    bif.commit_bp_valid = v;
    step();
    bif.commit_bp_valid = '0;
  endtask

  initial begin
    bit [0:5] exp_src;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bif.commit_bp_valid      = '0;
    set_lane(0, 32'h0);
    set_lane(1, 32'h0);
    bif.exbru_bp_valid       = 1'b0;
    bif.exbru_bp_pc          = 32'h0;
    bif.exbru_bp_instruction = 32'h0;
    bif.exbru_bp_jump        = 1'b0;
    bif.exbru_bp_next_pc     = 32'h0;
    bif.exbru_bp_hit         = 1'b0;
    bif.bp_sched_ready       = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_valid", 64'(bif.sched_bp_valid), 64'(0));
    chk("reset_ready", 64'(bif.sched_commit_ready), 64'(1));
    chk("reset_count", 64'(bif.sched_count), 64'(0));
    chk("reset_drop", 64'(bif.sched_exbru_drop_cnt), 64'(0));
    chk("reset_ovf", 64'(bif.sched_overflow), 64'(0));

    // Two-lane group drains in lane order
    push(2'b11, 32'h8010_0020, 32'h8010_0024);
    #1;
    chk("grp_count", 64'(bif.sched_count), 64'(2));
    chk("grp_pc0", 64'(bif.sched_bp_pc), 64'h8010_0020);
    chk("grp_src0", 64'(bif.sched_bp_src), 64'(0));
    step();
    chk("grp_pc1", 64'(bif.sched_bp_pc), 64'h8010_0024);
    step();
    chk("grp_empty", 64'(bif.sched_bp_valid), 64'(0));

    // Starvation guard: four exbru grants, then the FIFO head, then exbru again
    push(2'b01, 32'h8010_0040, 32'h0);
    bif.exbru_bp_valid       = 1'b1;
    bif.exbru_bp_pc          = 32'h80aa_bbc0;
    bif.exbru_bp_instruction = 32'h0000_1463;
    bif.exbru_bp_jump        = 1'b1;
    bif.exbru_bp_next_pc     = 32'h80aa_bc00;
    bif.exbru_bp_hit         = 1'b0;
    exp_src = 6'b111101;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("starve_src", 64'(bif.sched_bp_src), 64'(exp_src[k]));
      step();
    end
    bif.exbru_bp_valid = 1'b0;
    #1;
    chk("starve_drop", 64'(bif.sched_exbru_drop_cnt), 64'(1));
    chk("starve_count", 64'(bif.sched_count), 64'(0));

    // Predictor back-pressure: head held, exbru dropped each cycle
    bif.bp_sched_ready = 1'b0;
    push(2'b01, 32'h8010_0100, 32'h0);
    bif.exbru_bp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_count", 64'(bif.sched_count), 64'(1));
      step();
    end
    bif.exbru_bp_valid = 1'b0;
    #1;
    chk("bp_drop", 64'(bif.sched_exbru_drop_cnt), 64'(4));
    chk("bp_head_pc", 64'(bif.sched_bp_pc), 64'h8010_0100);
    step();
    chk("bp_head_stable", 64'(bif.sched_bp_pc), 64'h8010_0100);
    bif.bp_sched_ready = 1'b1;
    step();
    chk("bp_drained", 64'(bif.sched_count), 64'(0));

    // Fill to the ready boundary, then violate it with a partial accept
    bif.bp_sched_ready = 1'b0;
    push(2'b11, 32'h8010_0200, 32'h8010_0204);
    push(2'b11, 32'h8010_0208, 32'h8010_020c);
    push(2'b11, 32'h8010_0210, 32'h8010_0214);
    #1;
    chk("fill6_count", 64'(bif.sched_count), 64'(6));
    chk("fill6_ready", 64'(bif.sched_commit_ready), 64'(1));
    push(2'b10, 32'h8010_0fff, 32'h8010_0218);
    #1;
    chk("fill7_count", 64'(bif.sched_count), 64'(7));
    chk("fill7_ready", 64'(bif.sched_commit_ready), 64'(0));
    push(2'b11, 32'h8010_021c, 32'h8010_0220);
    #1;
    chk("ovf_count", 64'(bif.sched_count), 64'(8));
    chk("ovf_flag", 64'(bif.sched_overflow), 64'(1));
    chk("ovf_head", 64'(bif.sched_bp_pc), 64'h8010_0200);
    bif.bp_sched_ready = 1'b1;
    step();
    step();
    step();
    chk("drain3_count", 64'(bif.sched_count), 64'(5));
    chk("drain3_head", 64'(bif.sched_bp_pc), 64'h8010_020c);

    // Mid-operation reset discards the queue
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst2_count", 64'(bif.sched_count), 64'(0));
    chk("rst2_valid", 64'(bif.sched_bp_valid), 64'(0));
    chk("rst2_ovf", 64'(bif.sched_overflow), 64'(0));
    chk("rst2_drop", 64'(bif.sched_exbru_drop_cnt), 64'(0));
    push(2'b01, 32'h8010_0300, 32'h0);
    #1;
    chk("rst2_new_head", 64'(bif.sched_bp_pc), 64'h8010_0300);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
